load_ext_pipe: RTL
==================

# load_ext_pipe

Pipelined, parametrised load-data formatter between the data-memory read port and the writeback stage. Per load, it extracts a byte, half, word or (at 64 bit) dword from the raw read beat at a given byte offset. It then sign- or zero-extends the value to the register width and forwards it with its destination tag through a 2-entry elastic buffer with valid/ready handshaking. It replaces the fixed 16→32 immediate-style extender for load results and adds misalignment detection, flush, and optional LWL/LWR merging.

## Interface
Parameters:
- DATA_W, 32, register/memory beat width; legal values 32 or 64
- TAG_W, 5, width of the destination-register tag carried alongside the data
- OFF_W, $clog2(DATA_W/8), byte-offset width (derived; do not override)

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all buffered entries
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_data  in  DATA_W  raw memory read beat
- in_off  in  OFF_W  byte offset of access within beat
- in_size  in  2  0=byte, 1=half, 2=word, 3=dword
- in_uns  in  1  1=zero-extend, 0=sign-extend
- in_tag  in  TAG_W  destination tag
- in_lr  in  2  (LOAD_LR_EN only) 00 normal, 10 LWL, 01 LWR, 11 reserved→normal
- in_old  in  DATA_W  (LOAD_LR_EN only) current destination register value
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  formatted result
- out_tag  out  TAG_W  tag of out_data
- out_misalign  out  1  access misaligned or illegal; out_data is 0

## Operation
- Formatting is combinational on input; the result is captured into the buffer on handshake (in_valid && in_ready).
- Field = in_data[8*in_off +: 8<<in_size]. Upper bits are filled with the field MSB when in_uns=0, otherwise with 0.
- Misaligned: half with in_off[0]≠0; word with in_off[1:0]≠0; dword with in_off≠0. Illegal: in_size=3 when DATA_W=32. In both cases out_misalign=1 and out_data=0.
- Word at DATA_W=64 is extended to 64 bits exactly like half/byte.
- Buffer states: EMPTY, ONE, TWO. in_ready = (state≠TWO), registered.
  - EMPTY: accept → ONE.
  - ONE: accept without pop → TWO; pop without accept → EMPTY; accept and pop together → ONE.
  - TWO: pop → ONE; no accept possible.
- Output is strictly FIFO order. out_* are driven from the head entry and are stable while out_valid && !out_ready.
- flush: next state EMPTY. A beat presented in the same cycle as flush is dropped; a pop in that cycle is still counted by downstream.

## Timing
- Reset: state EMPTY, out_valid=0, in_ready=1, out_data=0, out_tag=0, out_misalign=0.
- Latency: beat accepted in cycle N appears with out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Backpressure: with out_ready=0, two beats are absorbed, then in_ready drops in the cycle after the second accept.
- resetn assertion mid-transfer clears everything immediately (asynchronous); buffered beats are lost.

## Configuration
- LOAD_LR_EN defined: in_lr and in_old exist. Let N=DATA_W/8 and k=in_off.
  - LWL: result = (in_data << 8*(N-1-k)) | (in_old & low 8*(N-1-k) bits).
  - LWR: result = (in_data >> 8k) | (in_old & high 8k bits).
  - LWL/LWR never flag misalignment and ignore in_size/in_uns.
- LOAD_LR_EN undefined: the ports are absent and every beat is a normal load.

## Structure
- Package load_ext_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D)
  - lr encodings (LR_NONE, LR_L, LR_R)
  - the buffer state enum
- Sub-module load_ext_fmt is the purely combinational field-extract/extend/merge/misalign logic.
- The top level holds the 2-entry buffer and handshake.

## Test plan
- DATA_W=32, in_data=0x8070_F0FF: byte off 1 signed gives 0xFFFF_FFF0; half off 2 unsigned gives 0x0000_8070; half off 2 signed gives 0xFFFF_8070.
- Word at off 2 → out_misalign=1, out_data=0. At DATA_W=32, size 3 → out_misalign=1.
- out_ready=0 with 3 back-to-back beats (tags 1, 2, 3): in_ready low after tag 2; release → outputs 1, 2, 3 in order, one per cycle.
- flush with two entries buffered plus a beat presented → out_valid=0 next cycle, in_ready=1, and no beat emerges afterwards.
- LOAD_LR_EN, in_data=0x4433_2211, in_old=0xAABB_CCDD:
  - LWL off 1 → 0x2211_CCDD.
  - LWR off 1 → 0xAA44_3322.
- Drop resetn mid-stream with a full buffer → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/load_ext_pkg.sv
// Shared encodings for the load-data formatter: access sizes, LWL/LWR selects, buffer states.
package load_ext_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] LR_NONE = 2'b00;
    localparam logic [1:0] LR_L    = 2'b10;
    localparam logic [1:0] LR_R    = 2'b01;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } buf_state_e;

endpackage

// File: rtl/load_ext_fmt.sv
// Combinational field extract, sign/zero extend and misalign detection for one load beat.
// With LOAD_LR_EN defined, also performs LWL/LWR merging with the old register value.
module load_ext_fmt
    import load_ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
`ifdef LOAD_LR_EN
    input  logic [1:0]        lr_i,
    input  logic [DATA_W-1:0] old_i,
`endif
    output logic [DATA_W-1:0] res_o,
    output logic              misalign_o
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] norm;
    logic              sgn;
    logic              mis;

    always_comb begin
        shifted = data_i >> {off_i, 3'b000};
        mask    = '1;
        sgn     = 1'b0;
        mis     = 1'b0;
        unique case (size_i)
            SZ_B: begin
                mask = DATA_W'(8'hFF);
                sgn  = shifted[7];
            end
            SZ_H: begin
                mask = DATA_W'(16'hFFFF);
                sgn  = shifted[15];
                mis  = off_i[0];
            end
            SZ_W: begin
                mask = DATA_W'(32'hFFFF_FFFF);
                sgn  = shifted[31];
                mis  = |off_i[1:0];
            end
            SZ_D: begin
                mask = '1;
                sgn  = shifted[DATA_W-1];
                // A dword cannot exist on a 32-bit beat.
                mis  = (DATA_W != 64) || (|off_i);
            end
            default: ;
        endcase
        norm = (shifted & mask) | ({DATA_W{sgn & ~uns_i}} & ~mask);
        if (mis) begin
            norm = '0;
        end
    end

`ifdef LOAD_LR_EN
    logic [OFF_W+2:0] lsh;
    logic [OFF_W+2:0] rsh;

    always_comb begin
        // N-1-k equals the bitwise complement of k within OFF_W bits.
        lsh        = {~off_i, 3'b000};
        rsh        = {off_i, 3'b000};
        res_o      = norm;
        misalign_o = mis;
        if (lr_i == LR_L) begin
            res_o      = (data_i << lsh) | (old_i & ~({DATA_W{1'b1}} << lsh));
            misalign_o = 1'b0;
        end else if (lr_i == LR_R) begin
            res_o      = (data_i >> rsh) | (old_i & ~({DATA_W{1'b1}} >> rsh));
            misalign_o = 1'b0;
        end
    end
`else
    assign res_o      = norm;
    assign misalign_o = mis;
`endif

endmodule

// File: rtl/load_ext_pipe.sv
// Load-data formatter feeding a 2-entry elastic buffer with valid/ready handshaking.
// Optional LWL/LWR merge enabled by defining LOAD_LR_EN.
module load_ext_pipe
    import load_ext_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [1:0]        in_size,
    input  logic              in_uns,
    input  logic [TAG_W-1:0]  in_tag,
`ifdef LOAD_LR_EN
    input  logic [1:0]        in_lr,
    input  logic [DATA_W-1:0] in_old,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_misalign
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              mis;
    } ent_t;

    ent_t       fmt_ent;
    ent_t       head_q, head_d, tail_q, tail_d;
    buf_state_e state_q, state_d;
    logic       in_ready_q, out_valid_q;
    logic       push, pop;

    load_ext_fmt #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_fmt (
        .data_i     (in_data),
        .off_i      (in_off),
        .size_i     (in_size),
        .uns_i      (in_uns),
`ifdef LOAD_LR_EN
        .lr_i       (in_lr),
        .old_i      (in_old),
`endif
        .res_o      (fmt_ent.data),
        .misalign_o (fmt_ent.mis)
    );

    assign fmt_ent.tag = in_tag;

    // A beat coinciding with flush is dropped.
    assign push = in_valid && in_ready_q && !flush;
    assign pop  = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = fmt_ent;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    tail_d  = fmt_ent;
                    state_d = StTwo;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end else if (push && pop) begin
                    head_d = fmt_ent;
                end
            end
            StTwo: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StEmpty;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != StTwo);
            out_valid_q <= (state_d != StEmpty);
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = head_q.data;
    assign out_tag      = head_q.tag;
    assign out_misalign = head_q.mis;

endmodule
